// File: rtl/mips_pkg.sv
// Shared MIPS datapath constants and types, plus a constant helper used by the
// register file read trees.
package mips_pkg;

    localparam int REG_WIDTH  = 32;
    localparam int NUM_REGS   = 32;
    localparam int REG_ADDR_W = 5;
    localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [REG_WIDTH-1:0]  word_t;

    // Depth of node idx in a heap-ordered 4-ary tree (root is depth 0).
    function automatic int heap_depth(input int idx);
        int depth;
        int first_next;
        depth      = 0;
        first_next = 1;
        while (idx >= first_next) begin
            depth      = depth + 1;
            first_next = first_next * 4 + 1;
        end
        return depth;
    endfunction

endpackage

// File: rtl/mips_mux.sv
// Shared 2:1 and 4:1 datapath mux cells.
module mips_mux2 #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sel,
    output logic [WIDTH-1:0] y
);

    // Two-way selection.
    always_comb begin
        if (sel) begin
            y = b;
        end else begin
            y = a;
        end
    end

endmodule

module mips_mux4 #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    input  logic [WIDTH-1:0] d3,
    input  logic [1:0]       sel,
    output logic [WIDTH-1:0] y
);

    // Four-way selection.
    always_comb begin
        y = '0;
        case (sel)
            2'd0:    y = d0;
            2'd1:    y = d1;
            2'd2:    y = d2;
            2'd3:    y = d3;
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/mips_regfile_rdmux.sv
// NUM_REGS:1 read selection tree: an optional 2:1 front rank on addr[0] when
// ADDR_W is odd, then a heap-ordered tree of 4:1 cells.
module mips_regfile_rdmux
    import mips_pkg::*;
#(
    parameter int WIDTH    = REG_WIDTH,
    parameter int NUM_REGS = mips_pkg::NUM_REGS,
    parameter int ADDR_W   = REG_ADDR_W
) (
    input  logic [NUM_REGS-1:0][WIDTH-1:0] regs,
    input  logic [ADDR_W-1:0]              addr,
    output logic [WIDTH-1:0]               data
);

    localparam int ODD   = ADDR_W % 2;
    localparam int M     = NUM_REGS >> ODD;
    localparam int D     = (ADDR_W - ODD) / 2;
    localparam int INT_N = (M - 1) / 3;
    localparam int NODES = INT_N + M;

    // Nodes 0..INT_N-1 are 4:1 cells, the rest are leaves feeding them.
    logic [WIDTH-1:0] node_s [NODES];

    if (ODD == 1) begin : g_pre
        for (genvar g = 0; g < M; g++) begin : g_leaf
            mips_mux2 #(.WIDTH(WIDTH)) u_mux (
                .a   (regs[2*g]),
                .b   (regs[2*g+1]),
                .sel (addr[0]),
                .y   (node_s[INT_N+g])
            );
        end
    end else begin : g_nopre
        for (genvar g = 0; g < M; g++) begin : g_leaf
            assign node_s[INT_N+g] = regs[g];
        end
    end

    for (genvar i = 0; i < INT_N; i++) begin : g_node
        localparam int DEP = heap_depth(i);
        localparam int LSB = ODD + 2 * (D - 1 - DEP);
        mips_mux4 #(.WIDTH(WIDTH)) u_mux (
            .d0  (node_s[4*i+1]),
            .d1  (node_s[4*i+2]),
            .d2  (node_s[4*i+3]),
            .d3  (node_s[4*i+4]),
            .sel (addr[LSB+1:LSB]),
            .y   (node_s[i])
        );
    end

    assign data = node_s[0];

endmodule

// File: rtl/regfile_reg.sv
// One architectural register: synchronous active-low clear, write-enabled load.
module regfile_reg #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_r;

    // Storage: clear has priority over a load.
    always_ff @(posedge clk) begin
        if (!reset) begin
            q_r <= '0;
        end else if (we) begin
            q_r <= d;
        end
    end

    assign q = q_r;

endmodule

// File: rtl/mips_regfile.sv
// MIPS 32-entry register file, $0 hardwired to zero, two combinational reads.
// Optional write-through bypass: define MIPS_REGFILE_BYPASS_EN.
module mips_regfile
    import mips_pkg::*;
#(
    parameter int WIDTH    = REG_WIDTH,
    parameter int NUM_REGS = mips_pkg::NUM_REGS,
    parameter int ADDR_W   = REG_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_enable,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    output logic [WIDTH-1:0]  rs_data,
    output logic [WIDTH-1:0]  rt_data
);

    logic [NUM_REGS-1:0]             dec_s;
    logic [NUM_REGS-1:0]             we_s;
    logic [NUM_REGS-1:0][WIDTH-1:0]  regs_s;
    logic [WIDTH-1:0]                rs_mux_s;
    logic [WIDTH-1:0]                rt_mux_s;

    // One-hot write enable; slot 0 never fires since $0 has no storage.
    always_comb begin
        dec_s = '0;
        we_s  = '0;
        for (int i = 1; i < NUM_REGS; i++) begin
            dec_s[i] = (wr_addr == ADDR_W'(i));
        end
        we_s    = dec_s & {NUM_REGS{wr_enable & reset}};
        we_s[0] = 1'b0;
    end

    assign regs_s[0] = '0;

    for (genvar r = 1; r < NUM_REGS; r++) begin : g_reg
        regfile_reg #(.WIDTH(WIDTH)) u_reg (
            .clk   (clk),
            .reset (reset),
            .we    (we_s[r]),
            .d     (wr_data),
            .q     (regs_s[r])
        );
    end

    mips_regfile_rdmux #(.WIDTH(WIDTH), .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W)) u_rs_mux (
        .regs (regs_s),
        .addr (rs_addr),
        .data (rs_mux_s)
    );

    mips_regfile_rdmux #(.WIDTH(WIDTH), .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W)) u_rt_mux (
        .regs (regs_s),
        .addr (rt_addr),
        .data (rt_mux_s)
    );

`ifdef MIPS_REGFILE_BYPASS_EN
    logic byp_ok_s;

    assign byp_ok_s = reset & wr_enable & (wr_addr != ADDR_W'(0));

    // Write-through: a read of the register being written sees the new value now.
    always_comb begin
        rs_data = rs_mux_s;
        rt_data = rt_mux_s;
        if (byp_ok_s && (rs_addr == wr_addr)) begin
            rs_data = wr_data;
        end else begin
            rs_data = rs_mux_s;
        end
        if (byp_ok_s && (rt_addr == wr_addr)) begin
            rt_data = wr_data;
        end else begin
            rt_data = rt_mux_s;
        end
    end
`else
    assign rs_data = rs_mux_s;
    assign rt_data = rt_mux_s;
`endif

endmodule

// File: tb/tb_mips_regfile.sv
// Directed bench for mips_regfile; expectations follow MIPS_REGFILE_BYPASS_EN.
module tb_mips_regfile;

    logic        clk;
    logic        reset;
    logic        wr_enable;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic [31:0] rs_data;
    logic [31:0] rt_data;

    int n_vec  = 0;
    int n_miss = 0;

    mips_regfile dut (
        .clk       (clk),
        .reset     (reset),
        .wr_enable (wr_enable),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rs_addr   (rs_addr),
        .rt_addr   (rt_addr),
        .rs_data   (rs_data),
        .rt_data   (rt_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        wr_enable = 1'b1;
        wr_addr   = a;
        wr_data   = d;
        tick();
        wr_enable = 1'b0;
    endtask

    function automatic logic [31:0] pat(input int i);
        logic [7:0] b;
        b = 8'(i);
        return {b, ~b, 8'(i * 3), 8'hC3};
    endfunction

    initial begin
        reset     = 1'b0;
        wr_enable = 1'b0;
        wr_addr   = 5'd0;
        wr_data   = 32'h0;
        rs_addr   = 5'd0;
        rt_addr   = 5'd0;
        tick();
        tick();
        reset = 1'b1;

        for (int i = 0; i < 32; i++) begin
            rs_addr = 5'(i);
            rt_addr = 5'(31 - i);
            #1;
            chk("rst_rs", rs_data, 32'h0);
            chk("rst_rt", rt_data, 32'h0);
        end

        wr(5'd5, 32'hDEADBEEF);
        rs_addr = 5'd5;
        #1;
        chk("r5_wr", rs_data, 32'hDEADBEEF);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        #1;
        chk("rst_clear", rs_data, 32'h0);

        wr(5'd1, 32'h00000001);
        wr(5'd31, 32'hFFFFFFFF);
        rs_addr = 5'd1;
        rt_addr = 5'd31;
        #1;
        chk("basic_r1", rs_data, 32'h00000001);
        chk("basic_r31", rt_data, 32'hFFFFFFFF);

        wr(5'd0, 32'h12345678);
        rs_addr = 5'd0;
        rt_addr = 5'd0;
        #1;
        chk("zero_rs", rs_data, 32'h0);
        chk("zero_rt", rt_data, 32'h0);
        rs_addr = 5'd1;
        #1;
        chk("zero_wr_r1", rs_data, 32'h00000001);

        wr(5'd7, 32'hAAAA5555);
        wr_enable = 1'b0;
        wr_addr   = 5'd7;
        wr_data   = 32'h0BADF00D;
        tick();
        rs_addr = 5'd7;
        #1;
        chk("wr_dis", rs_data, 32'hAAAA5555);

        wr(5'd9, 32'h11111111);
        wr_enable = 1'b1;
        wr_addr   = 5'd9;
        wr_data   = 32'h22222222;
        rs_addr   = 5'd9;
        rt_addr   = 5'd7;
        #1;
`ifdef MIPS_REGFILE_BYPASS_EN
        chk("same_pre", rs_data, 32'h22222222);
`else
        chk("same_pre", rs_data, 32'h11111111);
`endif
        chk("same_pre_rt", rt_data, 32'hAAAA5555);
        tick();
        wr_enable = 1'b0;
        rt_addr   = 5'd9;
        #1;
        chk("same_post_rs", rs_data, 32'h22222222);
        chk("same_post_rt", rt_data, 32'h22222222);

        wr(5'd3, 32'h0F0F0F0F);
        reset     = 1'b0;
        wr_enable = 1'b1;
        wr_addr   = 5'd3;
        wr_data   = 32'h33333333;
        rs_addr   = 5'd3;
        rt_addr   = 5'd0;
        #1;
`ifdef MIPS_REGFILE_BYPASS_EN
        chk("rstpri_pre", rs_data, 32'h0F0F0F0F);
`else
        chk("rstpri_pre", rs_data, 32'h0F0F0F0F);
`endif
        chk("rst_zero_rt", rt_data, 32'h0);
        tick();
        reset     = 1'b1;
        wr_enable = 1'b0;
        #1;
        chk("rst_prio", rs_data, 32'h0);
        wr(5'd3, 32'h33333333);
        #1;
        chk("rst_release", rs_data, 32'h33333333);

        for (int i = 0; i < 32; i++) begin
            wr(5'(i), pat(i));
        end
        for (int i = 0; i < 32; i++) begin
            rs_addr = 5'(i);
            rt_addr = 5'(31 - i);
            #1;
            chk("sweep_rs", rs_data, (i == 0) ? 32'h0 : pat(i));
            chk("sweep_rt", rt_data, (i == 31) ? 32'h0 : pat(31 - i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
